cube_counter: RTL and testbench

Counts cubes from two board push-buttons and drives the 7-bit `cube_num` bus consumed by the LED control stage. Each button is synchronized and debounced, then converted to a single press pulse. The pulses increment or decrement a bounded count. `cnt_event` flags every change of the count for other consumers.

---
 rtl/cube_counter.sv | 132 +++++++++++++
 tb/tb_cube_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cube_counter.sv
// Two-button debounced cube counter driving the 7-bit cube_num bus.
// Define CUBE_CNT_WRAP_EN for wrap-around at the bounds; default build saturates.

module cube_counter_btn #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic          r_stable_prev;
    logic [CW-1:0] r_cnt;
    logic          w_sync;

    assign w_sync = r_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync        <= '0;
            r_stable      <= 1'b0;
            r_stable_prev <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_sync        <= {r_sync[0], i_btn};
            r_stable_prev <= r_stable;
            // Any cycle that agrees with the accepted level restarts the qualification window.
            if (w_sync != r_stable) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= w_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_stable & ~r_stable_prev;
endmodule

module cube_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_CUBES       = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_add,
    input  logic       btn_sub,
    input  logic       clr,
    output logic [6:0] cube_num,
    output logic       cnt_event,
    output logic       at_max
);
    localparam logic [6:0] MAX_VAL = 7'(MAX_CUBES);

    logic       w_add;
    logic       w_sub;
    logic [6:0] w_next;
    logic       w_event;
    logic [6:0] r_cube_num;
    logic       r_cnt_event;

    cube_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_add),
        .o_press (w_add)
    );

    cube_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_sub),
        .o_press (w_sub)
    );

    always_comb begin
        w_next  = r_cube_num;
        w_event = 1'b0;
        if (clr) begin
            w_next  = '0;
            w_event = (r_cube_num != 7'd0);
        end else if (w_add && w_sub) begin
            w_next = r_cube_num;
        end else if (w_add) begin
            if (r_cube_num < MAX_VAL) begin
                w_next  = r_cube_num + 7'd1;
                w_event = 1'b1;
            end else begin
`ifdef CUBE_CNT_WRAP_EN
                w_next  = '0;
                w_event = 1'b1;
`else
                w_next  = r_cube_num;
`endif
            end
        end else if (w_sub) begin
            if (r_cube_num != 7'd0) begin
                w_next  = r_cube_num - 7'd1;
                w_event = 1'b1;
            end else begin
`ifdef CUBE_CNT_WRAP_EN
                w_next  = MAX_VAL;
                w_event = 1'b1;
`else
                w_next  = r_cube_num;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cube_num  <= '0;
            r_cnt_event <= 1'b0;
        end else begin
            r_cube_num  <= w_next;
            r_cnt_event <= w_event;
        end
    end

    assign cube_num  = r_cube_num;
    assign cnt_event = r_cnt_event;
    assign at_max    = (r_cube_num == MAX_VAL);
endmodule

// File: tb/tb_cube_counter.sv
// Directed bench for cube_counter with DEBOUNCE_CYCLES=4, MAX_CUBES=20.
// Expected values follow CUBE_CNT_WRAP_EN when the bench is built with it.

module tb_cube_counter;
    logic       clk;
    logic       rst;
    logic       btn_add;
    logic       btn_sub;
    logic       clr;
    logic [6:0] cube_num;
    logic       cnt_event;
    logic       at_max;

    int n_checks = 0;
    int n_err    = 0;
    int ev_cnt   = 0;

    cube_counter #(.DEBOUNCE_CYCLES(4), .MAX_CUBES(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_add   (btn_add),
        .btn_sub   (btn_sub),
        .clr       (clr),
        .cube_num  (cube_num),
        .cnt_event (cnt_event),
        .at_max    (at_max)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_event === 1'b1) ev_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        repeat (2) tick();
        rst = 1'b1;
        ev_cnt = 0;
    endtask

    task automatic press_add(input int n);
        for (int i = 0; i < n; i++) begin
            btn_add = 1'b1;
            repeat (8) tick();
            btn_add = 1'b0;
            repeat (8) tick();
        end
    endtask

    task automatic press_sub(input int n);
        for (int i = 0; i < n; i++) begin
            btn_sub = 1'b1;
            repeat (8) tick();
            btn_sub = 1'b0;
            repeat (8) tick();
        end
    endtask

    initial begin
        rst = 1'b1; btn_add = 1'b0; btn_sub = 1'b0; clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_cube_num", 32'(cube_num), 0);
        check("rst_cnt_event", 32'(cnt_event), 0);
        check("rst_at_max", 32'(at_max), 0);
        repeat (2) tick();
        rst = 1'b1;
        ev_cnt = 0;

        // single press: update lands on edge 7
        btn_add = 1'b1;
        repeat (6) tick();
        check("press_edge6_num", 32'(cube_num), 0);
        check("press_edge6_ev", 32'(ev_cnt), 0);
        tick();
        check("press_edge7_num", 32'(cube_num), 1);
        check("press_edge7_ev", 32'(cnt_event), 1);
        tick();
        check("press_edge8_ev", 32'(cnt_event), 0);
        repeat (12) tick();
        btn_add = 1'b0;
        repeat (10) tick();
        check("press_hold_num", 32'(cube_num), 1);
        check("press_hold_evs", 32'(ev_cnt), 1);

        // glitch rejection
        do_reset();
        for (int i = 0; i < 5; i++) begin
            btn_add = 1'b1;
            repeat (3) tick();
            btn_add = 1'b0;
            repeat (3) tick();
        end
        repeat (6) tick();
        check("glitch_num", 32'(cube_num), 0);
        check("glitch_evs", 32'(ev_cnt), 0);

        // upper bound
        press_add(20);
        check("fill_num", 32'(cube_num), 20);
        check("fill_at_max", 32'(at_max), 1);
        check("fill_evs", 32'(ev_cnt), 20);
        ev_cnt = 0;
        press_add(1);
`ifdef CUBE_CNT_WRAP_EN
        check("over_num", 32'(cube_num), 0);
        check("over_at_max", 32'(at_max), 0);
        check("over_evs", 32'(ev_cnt), 1);
        press_add(4);
        check("over5_num", 32'(cube_num), 4);
        check("over5_evs", 32'(ev_cnt), 5);
`else
        check("over_num", 32'(cube_num), 20);
        check("over_at_max", 32'(at_max), 1);
        check("over_evs", 32'(ev_cnt), 0);
        press_add(4);
        check("over5_num", 32'(cube_num), 20);
        check("over5_evs", 32'(ev_cnt), 0);
`endif

        // lower bound
        do_reset();
        press_sub(1);
`ifdef CUBE_CNT_WRAP_EN
        check("under_num", 32'(cube_num), 20);
        check("under_at_max", 32'(at_max), 1);
        check("under_evs", 32'(ev_cnt), 1);
        press_sub(2);
        check("under3_num", 32'(cube_num), 18);
        check("under3_evs", 32'(ev_cnt), 3);
`else
        check("under_num", 32'(cube_num), 0);
        check("under_at_max", 32'(at_max), 0);
        check("under_evs", 32'(ev_cnt), 0);
        press_sub(2);
        check("under3_num", 32'(cube_num), 0);
        check("under3_evs", 32'(ev_cnt), 0);
`endif

        // simultaneous and offset presses
        do_reset();
        press_add(5);
        check("pre_simul_num", 32'(cube_num), 5);
        ev_cnt = 0;
        btn_add = 1'b1; btn_sub = 1'b1;
        repeat (10) tick();
        btn_add = 1'b0; btn_sub = 1'b0;
        repeat (10) tick();
        check("simul_num", 32'(cube_num), 5);
        check("simul_evs", 32'(ev_cnt), 0);
        btn_add = 1'b1;
        tick();
        btn_sub = 1'b1;
        repeat (6) tick();
        check("offset_add_num", 32'(cube_num), 6);
        check("offset_add_ev", 32'(cnt_event), 1);
        tick();
        check("offset_sub_num", 32'(cube_num), 5);
        check("offset_sub_ev", 32'(cnt_event), 1);
        repeat (6) tick();
        btn_add = 1'b0; btn_sub = 1'b0;
        repeat (10) tick();
        check("offset_num", 32'(cube_num), 5);
        check("offset_evs", 32'(ev_cnt), 2);

        // clear priority over a coincident add pulse
        press_add(2);
        check("pre_clr_num", 32'(cube_num), 7);
        ev_cnt = 0;
        btn_add = 1'b1;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_num", 32'(cube_num), 0);
        check("clr_ev", 32'(cnt_event), 1);
        repeat (6) tick();
        btn_add = 1'b0;
        repeat (10) tick();
        check("clr_after_num", 32'(cube_num), 0);
        check("clr_after_evs", 32'(ev_cnt), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_zero_ev", 32'(cnt_event), 0);
        check("clr_zero_num", 32'(cube_num), 0);

        // reset mid-debounce with button still held
        press_add(9);
        check("pre_rst_num", 32'(cube_num), 9);
        btn_add = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("midrst_num", 32'(cube_num), 0);
        check("midrst_ev", 32'(cnt_event), 0);
        repeat (2) tick();
        rst = 1'b1;
        ev_cnt = 0;
        repeat (6) tick();
        check("rerun_edge6_num", 32'(cube_num), 0);
        tick();
        check("rerun_edge7_num", 32'(cube_num), 1);
        check("rerun_edge7_ev", 32'(cnt_event), 1);
        repeat (8) tick();
        btn_add = 1'b0;
        repeat (10) tick();
        check("rerun_num", 32'(cube_num), 1);
        check("rerun_evs", 32'(ev_cnt), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
